// File: rtl/accel_seq_pkg.sv
// Shared definitions for the accelerometer instruction sequencer:
// instruction opcodes, instruction word field positions, fault codes and
// the sequencer state encoding (also used by register_memory and the
// instruction-generation script).
package accel_seq_pkg;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02,
        OP_END   = 8'hFF
    } opcode_e;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 24;
    localparam int ADDR_MSB  = 23;
    localparam int ADDR_LSB  = 16;
    localparam int WDATA_MSB = 15;
    localparam int WDATA_LSB = 8;

    localparam logic [3:0] FC_NONE       = 4'h0;
    localparam logic [3:0] FC_BAD_ADDR   = 4'h1;
    localparam logic [3:0] FC_BAD_OP     = 4'h2;
    localparam logic [3:0] FC_END_OF_MEM = 4'hD;
    localparam logic [3:0] FC_TIMEOUT    = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_MEM,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_DONE,
        ST_FAULT
    } seq_state_e;

    function automatic logic is_bus_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks the instruction store from START_ADDR, decodes
// each word and issues accelerometer register WRITE/READ requests to the SPI
// master. Read bytes are returned on rd_data/rd_valid. One run per start pulse.
// Optional build macro SEQ_WATCHDOG_EN adds a timeout on the SPI handshake and
// response wait; without it the sequencer waits indefinitely.
module instr_sequencer
    import accel_seq_pkg::*;
#(
    parameter int MEMORY_SIZE    = 255,
    parameter int ADDR_W         = 8,
    parameter int START_ADDR     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_data,
    input  logic [3:0]        error_code,
    output logic              spi_req_valid,
    input  logic              spi_req_ready,
    output logic              spi_rw,
    output logic [7:0]        spi_addr,
    output logic [7:0]        spi_wdata,
    input  logic              spi_rsp_valid,
    input  logic [7:0]        spi_rsp_rdata,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [3:0]        fault_code
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic              rw_q, rw_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [3:0]        fault_code_q, fault_code_d;

    logic [7:0]        op_field;
    logic              wd_expired;
    logic              unused_reserved;

    assign op_field        = reg_data[OP_MSB:OP_LSB];
    assign unused_reserved = ^reg_data[7:0];

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Watchdog counts cycles spent in ISSUE/WAIT_RSP, restarting on every state change.
    always_comb begin
        wd_cnt_d = '0;
        if (state_d == state_q && (state_q == ST_ISSUE || state_q == ST_WAIT_RSP)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
    end

    assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    // Next-state logic: sequencing, decode, SPI handshake and fault handling.
    always_comb begin
        logic       step;
        logic       go_fault;
        logic [3:0] go_code;

        state_d      = state_q;
        pc_d         = pc_q;
        req_valid_d  = req_valid_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        step         = 1'b0;
        go_fault     = 1'b0;
        go_code      = FC_NONE;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    pc_d         = ADDR_W'(START_ADDR);
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                end
            end
            ST_FETCH:    state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: state_d = ST_DECODE;
            ST_DECODE: begin
                if (error_code != 4'h0) begin
                    go_fault = 1'b1;
                    go_code  = error_code;
                end else if (op_field == OP_NOP) begin
                    step = 1'b1;
                end else if (op_field == OP_END) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (is_bus_op(op_field)) begin
                    state_d     = ST_ISSUE;
                    req_valid_d = 1'b1;
                    rw_d        = (op_field == OP_READ);
                    addr_d      = reg_data[ADDR_MSB:ADDR_LSB];
                    wdata_d     = reg_data[WDATA_MSB:WDATA_LSB];
                end else begin
                    go_fault = 1'b1;
                    go_code  = FC_BAD_OP;
                end
            end
            ST_ISSUE: begin
                if (spi_req_ready) begin
                    state_d     = ST_WAIT_RSP;
                    req_valid_d = 1'b0;
                end else if (wd_expired) begin
                    go_fault = 1'b1;
                    go_code  = FC_TIMEOUT;
                end
            end
            ST_WAIT_RSP: begin
                if (spi_rsp_valid) begin
                    if (rw_q) begin
                        rd_data_d  = spi_rsp_rdata;
                        rd_valid_d = 1'b1;
                    end
                    step = 1'b1;
                end else if (wd_expired) begin
                    go_fault = 1'b1;
                    go_code  = FC_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            if (pc_q == ADDR_W'(MEMORY_SIZE)) begin
                go_fault = 1'b1;
                go_code  = FC_END_OF_MEM;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = ST_FETCH;
            end
        end

        if (go_fault) begin
            state_d      = ST_FAULT;
            req_valid_d  = 1'b0;
            busy_d       = 1'b0;
            fault_d      = 1'b1;
            fault_code_d = go_code;
        end
    end

    // State and registered outputs; reset aborts a run immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= ADDR_W'(START_ADDR);
            req_valid_q  <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign reg_addr      = pc_q;
    assign spi_req_valid = req_valid_q;
    assign spi_rw        = rw_q;
    assign spi_addr      = addr_q;
    assign spi_wdata     = wdata_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a registered instruction-store
// model, an SPI responder with programmable ready/response delays, a
// scoreboard of expected SPI requests and read bytes, a table of
// single-instruction programs and hand-written multi-cycle sequences.
// Build with SEQ_WATCHDOG_EN defined to also exercise the timeout.
module tb_instr_sequencer;
    import accel_seq_pkg::*;

`ifdef SEQ_WATCHDOG_EN
    localparam int TIMEOUT_CFG = 16;
    localparam int HOLD_CYCLES = 12;
`else
    localparam int TIMEOUT_CFG = 1024;
    localparam int HOLD_CYCLES = 20;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] reg_addr;
    logic [31:0] reg_data;
    logic [3:0] error_code;
    logic       spi_req_valid, spi_req_ready, spi_rw;
    logic [7:0] spi_addr, spi_wdata;
    logic       spi_rsp_valid;
    logic [7:0] spi_rsp_rdata;
    logic [7:0] rd_data;
    logic       rd_valid, busy, done, fault;
    logic [3:0] fault_code;

    instr_sequencer #(
        .MEMORY_SIZE(255), .ADDR_W(8), .START_ADDR(0), .TIMEOUT_CYCLES(TIMEOUT_CFG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .reg_addr(reg_addr),
        .reg_data(reg_data), .error_code(error_code),
        .spi_req_valid(spi_req_valid), .spi_req_ready(spi_req_ready),
        .spi_rw(spi_rw), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_rsp_valid(spi_rsp_valid), .spi_rsp_rdata(spi_rsp_rdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } spi_txn_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [3:0] err;
        logic       expDone;
        logic       expFault;
        logic [3:0] expCode;
        int         expReqs;
        int         expRd;
    } vec_t;

    logic [31:0] mem [256];
    logic [3:0]  errMem [256];
    spi_txn_t    expQ[$];
    logic [7:0]  rdExpQ[$];
    vec_t        vecs[10];

    int total = 0;
    int bad = 0;
    int reqCount = 0;
    int rdPulses = 0;
    int lastHold = 0;
    int readyWait = 0;
    int rspDelay = 0;
    bit noRsp = 0;
    bit rspPending = 0;
    int rspCnt = 0;
    int holdCnt = 0;
    logic [7:0] rspData = 8'h00;
    logic rspIsRead = 1'b0;

    // Instruction store model: registered read, data valid one cycle after address.
    always @(posedge clk) begin
        reg_data   <= mem[reg_addr];
        error_code <= errMem[reg_addr];
    end

    function automatic logic [31:0] mkWord(input logic [7:0] op, input logic [7:0] a, input logic [7:0] w);
        return {op, a, w, 8'h00};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // SPI responder: raises ready after readyWait held cycles, answers after rspDelay.
    initial begin
        spi_req_ready = 1'b0;
        spi_rsp_valid = 1'b0;
        spi_rsp_rdata = 8'h00;
        forever begin
            @(negedge clk);
            spi_rsp_valid = 1'b0;
            if (reset_n) begin
                if (rspPending && !noRsp) begin
                    rspCnt--;
                    if (rspCnt == 0) begin
                        spi_rsp_valid = 1'b1;
                        spi_rsp_rdata = rspData;
                        rspPending = 1'b0;
                        if (rspIsRead) rdExpQ.push_back(rspData);
                    end
                end
                if (spi_req_ready) begin
                    spi_req_ready = 1'b0;
                end else if (spi_req_valid) begin
                    if (expQ.size() > 0)
                        checkOutput("hold_fields", {spi_rw, spi_addr, spi_wdata},
                                    {expQ[0].rw, expQ[0].addr, expQ[0].wdata});
                    if (holdCnt == readyWait) begin
                        spi_req_ready = 1'b1;
                        lastHold = holdCnt;
                        holdCnt = 0;
                        reqCount++;
                        if (expQ.size() == 0) begin
                            reportTimeout("unexpected_request");
                        end else begin
                            spi_txn_t t;
                            t = expQ.pop_front();
                            checkOutput("req_rw", spi_rw, t.rw);
                            checkOutput("req_addr", spi_addr, t.addr);
                            checkOutput("req_wdata", spi_wdata, t.wdata);
                            rspData = t.rdata;
                        end
                        rspIsRead = spi_rw;
                        rspPending = 1'b1;
                        rspCnt = rspDelay + 1;
                    end else begin
                        holdCnt++;
                    end
                end
            end
        end
    end

    // Read-return monitor: each rd_valid pulse must match the next expected byte.
    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            rdPulses++;
            if (rdExpQ.size() == 0) reportTimeout("rd_unexpected");
            else checkOutput("rd_data", rd_data, rdExpQ.pop_front());
        end
    end

    task automatic tickSample();
        @(negedge clk);
        #1;
    endtask

    task automatic fillMem(input logic [31:0] word);
        for (int i = 0; i < 256; i++) begin
            mem[i] = word;
            errMem[i] = 4'h0;
        end
        expQ.delete();
        rdExpQ.delete();
        reqCount = 0;
        rdPulses = 0;
    endtask

    task automatic startPulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitFinish(input string name);
        int n = 0;
        while (!(done || fault) && n < 3000) begin
            tickSample();
            n++;
        end
        if (n >= 3000) reportTimeout(name);
        tickSample();
    endtask

    task automatic applyStimulus(input string name);
        startPulse();
        waitFinish(name);
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (reqCount == 0 && n < 200) begin
            tickSample();
            n++;
        end
        if (n >= 200) reportTimeout(name);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, spi_req_valid, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_flags"}, {done, fault, fault_code, rd_valid}, 7'h0);
        checkOutput({tag, "_fields"}, {spi_rw, spi_addr, spi_wdata, rd_data}, 25'h0);
        checkOutput({tag, "_addr"}, reg_addr, 8'h00);
    endtask

    task automatic resetDut();
        reset_n = 1'b0;
        noRsp = 1'b0;
        rspPending = 1'b0;
        holdCnt = 0;
        readyWait = 0;
        rspDelay = 0;
        spi_req_ready = 1'b0;
        spi_rsp_valid = 1'b0;
        expQ.delete();
        rdExpQ.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        fillMem(mkWord(OP_END, 8'h00, 8'h00));

        vecs[0] = '{8'h01, 8'h2D, 8'h08, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 1, 0};
        vecs[1] = '{8'h02, 8'h32, 8'h00, 8'hA5, 4'h0, 1'b1, 1'b0, 4'h0, 1, 1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 0, 0};
        vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 0, 0};
        vecs[4] = '{8'h07, 8'h10, 8'h20, 8'h00, 4'h0, 1'b0, 1'b1, 4'h2, 0, 0};
        vecs[5] = '{8'h01, 8'h31, 8'h0B, 8'h00, 4'h1, 1'b0, 1'b1, 4'h1, 0, 0};
        vecs[6] = '{8'h02, 8'h0F, 8'h00, 8'h5A, 4'h0, 1'b1, 1'b0, 4'h0, 1, 1};
        vecs[7] = '{8'h03, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 4'h2, 0, 0};
        vecs[8] = '{8'h01, 8'h20, 8'hA7, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 1, 0};
        vecs[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'h9, 1'b0, 1'b1, 4'h9, 0, 0};

        tickSample();
        checkResetOutputs("reset");
        resetDut();

        $display("[TB] table-driven single-instruction programs");
        for (int i = 0; i < 10; i++) begin
            fillMem(mkWord(OP_END, 8'h00, 8'h00));
            mem[0] = mkWord(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            errMem[0] = vecs[i].err;
            if (vecs[i].expReqs > 0)
                expQ.push_back('{(vecs[i].op == 8'h02), vecs[i].addr, vecs[i].wdata, vecs[i].rdata});
            readyWait = i % 3;
            rspDelay = i % 4;
            applyStimulus("table_run");
            checkOutput("tbl_done", done, vecs[i].expDone);
            checkOutput("tbl_fault", fault, vecs[i].expFault);
            checkOutput("tbl_code", fault_code, vecs[i].expCode);
            checkOutput("tbl_busy", busy, 1'b0);
            checkOutput("tbl_reqs", reqCount, vecs[i].expReqs);
            checkOutput("tbl_rd_pulses", rdPulses, vecs[i].expRd);
            if (vecs[i].expRd > 0) checkOutput("tbl_rd_data", rd_data, vecs[i].rdata);
        end

        $display("[TB] request held while ready is low");
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        mem[0] = mkWord(OP_WRITE, 8'h1E, 8'h55);
        expQ.push_back('{1'b0, 8'h1E, 8'h55, 8'h00});
        readyWait = HOLD_CYCLES;
        applyStimulus("hold_run");
        checkOutput("hold_cycles", lastHold, HOLD_CYCLES);
        checkOutput("hold_done", {done, fault}, 2'b10);
        readyWait = 0;

        $display("[TB] bad address after NOPs");
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        for (int i = 0; i < 5; i++) mem[i] = mkWord(OP_NOP, 8'h00, 8'h00);
        mem[5] = mkWord(OP_WRITE, 8'h2D, 8'h08);
        errMem[5] = 4'h1;
        applyStimulus("badaddr_run");
        checkOutput("badaddr_code", {fault, fault_code}, 5'h11);
        checkOutput("badaddr_reqs", reqCount, 0);
        checkOutput("badaddr_pc", reg_addr, 8'h05);

        $display("[TB] bad opcode then restart");
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        mem[0] = mkWord(8'h07, 8'h00, 8'h00);
        applyStimulus("badop_run");
        checkOutput("badop_code", {fault, fault_code}, 5'h12);
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        mem[0] = mkWord(OP_WRITE, 8'h2C, 8'h0A);
        expQ.push_back('{1'b0, 8'h2C, 8'h0A, 8'h00});
        readyWait = 6;
        startPulse();
        #1;
        checkOutput("restart_flags", {busy, done, fault, fault_code}, 7'b100_0000);
        checkOutput("restart_addr", reg_addr, 8'h00);
        begin
            int n = 0;
            while (!spi_req_valid && n < 50) begin tickSample(); n++; end
            if (n >= 50) reportTimeout("restart_valid_wait");
        end
        startPulse();
        #1;
        checkOutput("busy_start_ignored", {spi_req_valid, busy, reg_addr}, {2'b11, 8'h00});
        waitFinish("restart_run");
        checkOutput("restart_done", {done, fault}, 2'b10);
        checkOutput("restart_reqs", reqCount, 1);
        readyWait = 0;

        $display("[TB] run off the end of memory");
        fillMem(mkWord(OP_NOP, 8'h00, 8'h00));
        applyStimulus("eom_run");
        checkOutput("eom_code", {fault, fault_code}, 5'h1D);
        checkOutput("eom_pc", reg_addr, 8'hFF);

`ifdef SEQ_WATCHDOG_EN
        $display("[TB] watchdog on missing response");
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        mem[0] = mkWord(OP_WRITE, 8'h2D, 8'h08);
        expQ.push_back('{1'b0, 8'h2D, 8'h08, 8'h00});
        noRsp = 1'b1;
        startPulse();
        waitReq("wd_req_wait");
        begin
            int n = 0;
            forever begin
                tickSample();
                if (fault || n >= 100) break;
                n++;
            end
            checkOutput("wd_cycles", n, 16);
        end
        checkOutput("wd_code", {fault, fault_code, spi_req_valid}, 6'b1_1110_0);
        resetDut();
`endif

        $display("[TB] asynchronous reset in WAIT_RSP");
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        mem[0] = mkWord(OP_READ, 8'h32, 8'h00);
        expQ.push_back('{1'b1, 8'h32, 8'h00, 8'hA5});
        noRsp = 1'b1;
        startPulse();
        waitReq("rsp_req_wait");
        tickSample();
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("rst_waitrsp");
        resetDut();

        $display("[TB] asynchronous reset in ISSUE");
        fillMem(mkWord(OP_END, 8'h00, 8'h00));
        mem[0] = mkWord(OP_WRITE, 8'h2D, 8'h08);
        expQ.push_back('{1'b0, 8'h2D, 8'h08, 8'h00});
        readyWait = 50;
        startPulse();
        begin
            int n = 0;
            while (!spi_req_valid && n < 50) begin tickSample(); n++; end
            if (n >= 50) reportTimeout("issue_valid_wait");
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("rst_issue");
        resetDut();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
